// File: rtl/joy_pkg.sv
// Shared definitions for the DB15 joystick link.
// Button bit positions and shift-chain FSM states.
package joy_pkg;

  localparam int BTN_R  = 0;
  localparam int BTN_L  = 1;
  localparam int BTN_D  = 2;
  localparam int BTN_U  = 3;
  localparam int BTN_A  = 4;
  localparam int BTN_B  = 5;
  localparam int BTN_C  = 6;
  localparam int BTN_D2 = 7;
  localparam int BTN_E  = 8;
  localparam int BTN_F  = 9;
  localparam int BTN_S  = 10;
  localparam int BTN_LS = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } joy_state_e;

endpackage

// File: rtl/joy_sync_edge.sv
// Multi-stage synchroniser for an asynchronous host strobe.
// Adds a history flop and reports the synced level and its edges.
module joy_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              hist;

  // Shift the pin through the chain; idle line level is 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '1;
      hist <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], pin};
      hist <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = ~hist & level;
  assign fall  = hist & ~level;

endmodule

// File: rtl/joy_db15_tx.sv
// Device-side DB15 joystick responder.
// Emulates a '165-style load/shift chain clocked by the host.
module joy_db15_tx
  import joy_pkg::*;
#(
  parameter int BITS_PER_PLAYER = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT         = 4096
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [BITS_PER_PLAYER-1:0] joystick1,
  input  logic [BITS_PER_PLAYER-1:0] joystick2,
  input  logic                       joy_clk,
  input  logic                       joy_load,
  output logic                       joy_data,
  output logic                       frame_done,
  output logic                       active
);

  localparam int FRAME = 2 * BITS_PER_PLAYER;
  localparam int CW    = $clog2(FRAME);
  localparam int WW    = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME - 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT - 1);

  joy_state_e       state, state_n;
  logic [FRAME-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WW-1:0]    wd, wd_n;

  logic load_lvl, load_fall, load_rise;
  logic clk_lvl, clk_rise, clk_fall;
  logic unused_edges;

  logic [FRAME-1:0] latch;
  logic [FRAME-1:0] shifted;
  logic             busy_n;

  joy_sync_edge #(.STAGES(SYNC_STAGES)) u_load_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (joy_load),
    .level   (load_lvl),
    .rise    (load_rise),
    .fall    (load_fall)
  );

  joy_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (joy_clk),
    .level   (clk_lvl),
    .rise    (clk_rise),
    .fall    (clk_fall)
  );

  assign unused_edges = ^{load_rise, clk_lvl, clk_fall};

  assign latch   = ~{joystick2, joystick1};
  assign shifted = {1'b1, shreg[FRAME-1:1]};

  // Next-state logic for the load/shift chain and host watchdog.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    if (clk_rise || load_fall)
      wd_n = '0;
    else if (&wd)
      wd_n = wd;
    else
      wd_n = wd + 1'b1;

    unique case (state)
      IDLE: begin
        if (load_fall) begin
          state_n = LOADED;
          shreg_n = latch;
          cnt_n   = '0;
        end
      end
      LOADED: begin
        if (!load_lvl) begin
          shreg_n = latch;
        end else if (clk_rise) begin
          state_n = SHIFT;
          shreg_n = shifted;
          cnt_n   = CW'(1);
        end
      end
      SHIFT: begin
        if (load_fall) begin
          state_n = LOADED;
          shreg_n = latch;
          cnt_n   = '0;
        end else if (clk_rise) begin
          shreg_n = shifted;
          if (cnt == LAST_BIT)
            state_n = DONE;
          else
            cnt_n = cnt + 1'b1;
        end else if (wd >= WD_LIMIT) begin
          state_n = IDLE;
        end
      end
      DONE: begin
        cnt_n = '0;
        if (load_fall) begin
          state_n = LOADED;
          shreg_n = latch;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_n = (state_n == LOADED) || (state_n == SHIFT);

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shreg      <= '1;
      cnt        <= '0;
      wd         <= '0;
      joy_data   <= 1'b1;
      frame_done <= 1'b0;
      active     <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      wd         <= wd_n;
      joy_data   <= busy_n ? shreg_n[0] : 1'b1;
      frame_done <= (state_n == DONE);
      active     <= busy_n;
    end
  end

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: host-side stimulus with a bit scoreboard.
// A monitor pops expected bits on each host JOY_CLK rise.
module tb_joy_db15_tx;

  localparam int SS = 2;
  localparam int TO = 4096;
  localparam int PH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] joystick1 = '0;
  logic [15:0] joystick2 = '0;
  logic        joy_clk = 1'b1;
  logic        joy_load = 1'b1;
  logic        joy_data;
  logic        frame_done;
  logic        active;

  int   n_chk = 0;
  int   n_fail = 0;
  int   fd_cnt = 0;
  int   cyc = 0;
  int   bit_idx = 0;
  int   rise_cyc = 0;
  bit   mon_en = 1'b0;
  logic exp_q[$];

  joy_db15_tx #(
    .BITS_PER_PLAYER (16),
    .SYNC_STAGES     (SS),
    .TIMEOUT         (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joy_data   (joy_data),
    .frame_done (frame_done),
    .active     (active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the host samples JOY_DATA right at its rising edge.
  always @(posedge joy_clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_pop: no expected bit, joy_data=%b", joy_data);
      end else begin
        check($sformatf("bit%0d", bit_idx), 32'(joy_data),
              32'(exp_q.pop_front()));
        bit_idx++;
      end
    end
  end

  task automatic do_load();
    @(negedge clk);
    joy_load = 1'b0;
    bit_idx = 0;
    repeat (PH) @(negedge clk);
    joy_load = 1'b1;
    repeat (PH) @(negedge clk);
  endtask

  task automatic pulse(input bit last);
    joy_clk = 1'b0;
    repeat (PH) @(negedge clk);
    joy_clk = 1'b1;
    rise_cyc = cyc;
    for (int k = 1; k <= PH; k++) begin
      @(negedge clk);
      if (last)
        check($sformatf("frame_done_k%0d", k), 32'(frame_done),
              32'(k == SS + 1));
    end
  endtask

  task automatic shift(input logic [31:0] frame, input int n, input bit full);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(frame[i]);
      pulse(full && (i == n - 1));
    end
  endtask

  int bad;
  int fd0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_joy_data", 32'(joy_data), 32'h1);
    check("rst_active", 32'(active), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    reset_n = 1'b1;
    mon_en = 1'b1;

    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (joy_data !== 1'b1 || active !== 1'b0 || frame_done !== 1'b0)
        bad++;
    end
    check("idle_quiet", 32'(bad), 32'h0);

    // Basic frame: P1 R and A, P2 LS pressed.
    fd0 = fd_cnt;
    joystick1 = 16'h0011;
    joystick2 = 16'h0800;
    do_load();
    check("loaded_active", 32'(active), 32'h1);
    check("loaded_bit0", 32'(joy_data), 32'h0);
    shift(32'hF7FF_FFEE, 32, 1'b1);
    repeat (4) @(negedge clk);
    check("f1_done_count", 32'(fd_cnt - fd0), 32'h1);
    check("f1_idle_data", 32'(joy_data), 32'h1);
    check("f1_idle_active", 32'(active), 32'h0);

    // Transparent load while the strobe is held low.
    fd0 = fd_cnt;
    joystick1 = 16'h0000;
    joystick2 = 16'h0000;
    @(negedge clk);
    joy_load = 1'b0;
    bit_idx = 0;
    repeat (10) @(negedge clk);
    check("transp_old", 32'(joy_data), 32'h1);
    joystick1 = 16'h0001;
    repeat (10) @(negedge clk);
    check("transp_new", 32'(joy_data), 32'h0);
    joy_load = 1'b1;
    repeat (PH) @(negedge clk);
    shift(32'hFFFF_FFFE, 32, 1'b1);
    repeat (4) @(negedge clk);
    check("f2_done_count", 32'(fd_cnt - fd0), 32'h1);

    // Aborted frame: reload after 5 bits, then a full frame.
    fd0 = fd_cnt;
    joystick1 = 16'h0C30;
    joystick2 = 16'h000F;
    do_load();
    shift(32'hFFF0_F3CF, 5, 1'b0);
    check("abort_no_done", 32'(fd_cnt - fd0), 32'h0);
    do_load();
    shift(32'hFFF0_F3CF, 32, 1'b1);
    repeat (4) @(negedge clk);
    check("f3_done_count", 32'(fd_cnt - fd0), 32'h1);

    // Watchdog: 3 bits then the host goes quiet.
    fd0 = fd_cnt;
    joystick1 = 16'h0002;
    joystick2 = 16'h0000;
    do_load();
    shift(32'hFFFF_FFFD, 3, 1'b0);
    while (cyc < rise_cyc + SS + 1 + TO - 1) @(negedge clk);
    check("to_active_before", 32'(active), 32'h1);
    @(negedge clk);
    check("to_active_after", 32'(active), 32'h0);
    check("to_joy_data", 32'(joy_data), 32'h1);
    repeat (10) @(negedge clk);
    check("to_no_done", 32'(fd_cnt - fd0), 32'h0);

    // Asynchronous reset in the middle of a shift.
    joystick1 = 16'h0000;
    joystick2 = 16'h0000;
    do_load();
    shift(32'hFFFF_FFFF, 10, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_joy_data", 32'(joy_data), 32'h1);
    check("mid_rst_active", 32'(active), 32'h0);
    check("mid_rst_frame_done", 32'(frame_done), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_active", 32'(active), 32'h0);

    fd0 = fd_cnt;
    joystick1 = 16'hFFFF;
    joystick2 = 16'h5555;
    do_load();
    shift(32'hAAAA_0000, 32, 1'b1);
    repeat (4) @(negedge clk);
    check("f5_done_count", 32'(fd_cnt - fd0), 32'h1);
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
